// File: rtl/arp_pkg.sv
// Shared definitions for the arpeggio sequencer: pattern codes, FSM states,
// REST marker and the LFSR seed/taps used by RANDOM mode.
package arp_pkg;

    typedef enum logic [1:0] {
        PAT_UP     = 2'd0,
        PAT_DOWN   = 2'd1,
        PAT_UPDOWN = 2'd2,
        PAT_RANDOM = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    localparam int unsigned REST = 0;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 -> feedback from bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/arp_lfsr.sv
// 16-bit Fibonacci LFSR with step enable; reseeds on asynchronous reset.
module arp_lfsr
    import arp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/arp_sequencer.sv
// Arpeggiator: steps through a small chord table at a tick-counted note
// length and presents the sounding slot's phase increment to a DDS.
module arp_sequencer
    import arp_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned MAX_NOTES   = 4,
    parameter int unsigned DUR_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_tick,
    input  logic                   run,
    input  logic [1:0]             pattern,
    input  logic [2:0]             num_notes,
    input  logic [DUR_WIDTH-1:0]   note_dur,
    input  logic                   wr_en,
    input  logic [1:0]             wr_addr,
    input  logic [PHASE_WIDTH-1:0] wr_data,
    output logic [PHASE_WIDTH-1:0] delta,
    output logic [1:0]             note_idx,
    output logic                   note_start,
    output logic                   gate
);

    state_e                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic                   dir_down_q, dir_down_d;
    logic [DUR_WIDTH-1:0]   dur_cnt_q, dur_cnt_d;
    logic [PHASE_WIDTH-1:0] delta_q, delta_d;
    logic                   gate_q, gate_d;
    logic                   note_start_q, note_start_d;
    logic [PHASE_WIDTH-1:0] chord_q [MAX_NOTES];
    logic [PHASE_WIDTH-1:0] chord_d [MAX_NOTES];

    pattern_e               pat;
    logic [2:0]             num_eff, last, idx3, adv_idx;
    logic                   adv_dir_down;
    logic [DUR_WIDTH-1:0]   dur_eff;
    logic [7:0]             rnd;
    logic [15:0]            lfsr_val;
    logic                   lfsr_step;
    logic                   load;
    logic [1:0]             load_idx;

    arp_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    assign pat  = pattern_e'(pattern);
    assign idx3 = {1'b0, idx_q};
    assign last = num_eff - 3'd1;
    assign rnd  = lfsr_val[7:0] % {5'd0, num_eff};

    always_comb begin
        if (num_notes == 3'd0) begin
            num_eff = 3'd1;
        end else if (32'(num_notes) > MAX_NOTES) begin
            num_eff = 3'(MAX_NOTES);
        end else begin
            num_eff = num_notes;
        end
        dur_eff = (note_dur == '0) ? DUR_WIDTH'(1) : note_dur;
    end

    // Index the sequence would move to if the current note ends this cycle
    always_comb begin
        adv_idx      = '0;
        adv_dir_down = 1'b0;
        if (idx3 >= num_eff) begin
            adv_idx = (pat == PAT_DOWN) ? last : 3'd0;
        end else begin
            case (pat)
                PAT_UP:   adv_idx = (idx3 == last) ? 3'd0 : idx3 + 3'd1;
                PAT_DOWN: adv_idx = (idx3 == 3'd0) ? last : idx3 - 3'd1;
                PAT_UPDOWN: begin
                    if (num_eff == 3'd1) begin
                        adv_idx = 3'd0;
                    end else if (!dir_down_q) begin
                        if (idx3 == last) begin
                            adv_idx      = idx3 - 3'd1;
                            adv_dir_down = 1'b1;
                        end else begin
                            adv_idx = idx3 + 3'd1;
                        end
                    end else if (idx3 == 3'd0) begin
                        adv_idx = 3'd1;
                    end else begin
                        adv_idx      = idx3 - 3'd1;
                        adv_dir_down = 1'b1;
                    end
                end
                default:  adv_idx = rnd[2:0];
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dir_down_d = dir_down_q;
        dur_cnt_d  = dur_cnt_q;
        delta_d    = delta_q;
        gate_d     = gate_q;
        load       = 1'b0;
        load_idx   = '0;
        lfsr_step  = 1'b0;
        chord_d    = chord_q;
        if (wr_en && (32'(wr_addr) < MAX_NOTES)) begin
            chord_d[wr_addr] = wr_data;
        end

        case (state_q)
            ST_IDLE: begin
                dur_cnt_d  = '0;
                delta_d    = '0;
                gate_d     = 1'b0;
                dir_down_d = 1'b0;
                if (run) begin
                    state_d  = ST_PLAY;
                    load     = 1'b1;
                    load_idx = (pat == PAT_DOWN) ? last[1:0] : 2'd0;
                end
            end
            default: begin
                if (!run) begin
                    state_d    = ST_IDLE;
                    dur_cnt_d  = '0;
                    delta_d    = '0;
                    gate_d     = 1'b0;
                    dir_down_d = 1'b0;
                end else if (sample_tick) begin
                    if (dur_cnt_q == dur_eff - DUR_WIDTH'(1)) begin
                        dur_cnt_d  = '0;
                        load       = 1'b1;
                        load_idx   = adv_idx[1:0];
                        dir_down_d = adv_dir_down;
                        lfsr_step  = (pat == PAT_RANDOM);
                    end else begin
                        dur_cnt_d = dur_cnt_q + DUR_WIDTH'(1);
                    end
                end
            end
        endcase

        // Reads chord_q, so a same-edge write to this slot is heard next time
        if (load) begin
            idx_d   = load_idx;
            delta_d = chord_q[load_idx];
            gate_d  = (chord_q[load_idx] != PHASE_WIDTH'(REST));
        end
        note_start_d = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            dir_down_q   <= 1'b0;
            dur_cnt_q    <= '0;
            delta_q      <= '0;
            gate_q       <= 1'b0;
            note_start_q <= 1'b0;
            chord_q      <= '{default: '0};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dir_down_q   <= dir_down_d;
            dur_cnt_q    <= dur_cnt_d;
            delta_q      <= delta_d;
            gate_q       <= gate_d;
            note_start_q <= note_start_d;
            chord_q      <= chord_d;
        end
    end

    assign delta      = delta_q;
    assign note_idx   = idx_q;
    assign note_start = note_start_q;
    assign gate       = gate_q;

endmodule

// File: tb/tb_arp_sequencer.sv
// Randomized and directed bench for arp_sequencer against a note-level
// reference model (bounce position, integer LFSR, chord array).
module tb_arp_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sample_tick = 1'b0;
    logic        run = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [2:0]  num_notes = 3'd3;
    logic [15:0] note_dur = 16'd4;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] delta;
    logic [1:0]  note_idx;
    logic        note_start;
    logic        gate;

    arp_sequencer #(.PHASE_WIDTH(32), .MAX_NOTES(4), .DUR_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .run         (run),
        .pattern     (pattern),
        .num_notes   (num_notes),
        .note_dur    (note_dur),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .delta       (delta),
        .note_idx    (note_idx),
        .note_start  (note_start),
        .gate        (gate)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int unsigned m_chord [4];
    int          m_play, m_idx, m_p, m_cnt;
    int unsigned m_lfsr, m_delta;
    int          m_gate, m_start;

    int unsigned st_delta [$];
    int          st_idx [$];
    int          st_cyc [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned lfsr_next(input int unsigned s);
        int unsigned fb;
        fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
        return ((s << 1) | fb) & 32'hFFFF;
    endfunction

    function automatic void model_reset();
        m_play = 0; m_idx = 0; m_p = 0; m_cnt = 0;
        m_lfsr = 32'hACE1; m_delta = 0; m_gate = 0; m_start = 0;
        for (int i = 0; i < 4; i++) m_chord[i] = 0;
    endfunction

    // Bounce is modelled as a position on a 2*(n-1) cycle folded back onto 0..n-1
    function automatic int next_idx(input int n);
        int r;
        if (m_idx >= n) begin
            m_p = 0;
            r = (pattern == 2'd1) ? n - 1 : 0;
            if (pattern == 2'd3) m_lfsr = lfsr_next(m_lfsr);
            return r;
        end
        case (pattern)
            2'd0: begin m_p = 0; r = (m_idx + 1) % n; end
            2'd1: begin m_p = 0; r = (m_idx + n - 1) % n; end
            2'd2: begin
                if (n == 1) begin
                    m_p = 0; r = 0;
                end else begin
                    m_p = (m_p + 1) % (2 * (n - 1));
                    r = (m_p < n) ? m_p : 2 * (n - 1) - m_p;
                end
            end
            default: begin
                m_p = 0;
                r = int'(m_lfsr % 256) % n;
                m_lfsr = lfsr_next(m_lfsr);
            end
        endcase
        return r;
    endfunction

    function automatic void model_edge();
        int n, d, load, nidx;
        if (!rst_n) begin
            model_reset();
            return;
        end
        n = (num_notes == 0) ? 1 : (num_notes > 4) ? 4 : int'(num_notes);
        d = (note_dur == 0) ? 1 : int'(note_dur);
        load = 0;
        nidx = m_idx;
        if (m_play == 0) begin
            if (run) begin
                m_play = 1; load = 1; m_cnt = 0; m_p = 0;
                nidx = (pattern == 2'd1) ? n - 1 : 0;
            end
        end else if (!run) begin
            m_play = 0; m_delta = 0; m_gate = 0; m_cnt = 0; m_p = 0;
        end else if (sample_tick) begin
            if (m_cnt == d - 1) begin
                m_cnt = 0; load = 1;
                nidx = next_idx(n);
            end else begin
                m_cnt = (m_cnt + 1) % 65536;
            end
        end
        if (load != 0) begin
            m_idx = nidx;
            m_delta = m_chord[nidx];
            m_gate = (m_delta != 0) ? 1 : 0;
        end
        m_start = load;
        if (wr_en) m_chord[wr_addr] = wr_data;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_eq("delta", 64'(delta), 64'(m_delta));
        check_eq("note_idx", 64'(note_idx), 64'(m_idx));
        check_eq("gate", 64'(gate), 64'(m_gate));
        check_eq("note_start", 64'(note_start), 64'(m_start));
        if (note_start) begin
            st_delta.push_back(delta);
            st_idx.push_back(int'(note_idx));
            st_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_log();
        st_delta.delete(); st_idx.delete(); st_cyc.delete();
    endtask

    task automatic write_slot(input logic [1:0] a, input logic [31:0] v);
        wr_en = 1'b1; wr_addr = a; wr_data = v;
        step();
        wr_en = 1'b0;
    endtask

    task automatic stop_run();
        run = 1'b0;
        step(); step();
    endtask

    task automatic play(input logic [1:0] pat, input int cycles);
        pattern = pat; run = 1'b1; clear_log();
        for (int i = 0; i < cycles; i++) step();
    endtask

    int up_exp [4]     = '{38222, 45450, 51020, 38222};
    int updown_exp [6] = '{0, 1, 2, 1, 0, 1};
    int down_exp [4]   = '{2, 1, 0, 2};
    int seen;

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_delta", 64'(delta), 64'd0);
        check_eq("rst_gate", 64'(gate), 64'd0);
        check_eq("rst_idx", 64'(note_idx), 64'd0);
        check_eq("rst_start", 64'(note_start), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        sample_tick = 1'b1; num_notes = 3'd3; note_dur = 16'd4;
        write_slot(2'd0, 32'd38222);
        write_slot(2'd1, 32'd45450);
        write_slot(2'd2, 32'd51020);

        play(2'd0, 14);
        check_eq("up_count", 64'(st_delta.size()), 64'd4);
        for (int i = 0; i < 4 && i < st_delta.size(); i++) begin
            check_eq("up_delta", 64'(st_delta[i]), 64'(up_exp[i]));
            if (i > 0) check_eq("up_spacing", 64'(st_cyc[i] - st_cyc[i-1]), 64'd4);
        end
        stop_run();

        play(2'd2, 21);
        check_eq("ud_count", 64'(st_idx.size()), 64'd6);
        for (int i = 0; i < 6 && i < st_idx.size(); i++)
            check_eq("updown_idx", 64'(st_idx[i]), 64'(updown_exp[i]));
        stop_run();

        play(2'd1, 13);
        check_eq("down_count", 64'(st_idx.size()), 64'd4);
        for (int i = 0; i < 4 && i < st_idx.size(); i++)
            check_eq("down_idx", 64'(st_idx[i]), 64'(down_exp[i]));
        stop_run();

        write_slot(2'd1, 32'd0);
        play(2'd0, 14);
        for (int i = 0; i < st_idx.size(); i++)
            check_eq("rest_gate", 64'(st_delta[i] != 0), (st_idx[i] == 1) ? 64'd0 : 64'd1);
        stop_run();
        write_slot(2'd1, 32'd45450);

        play(2'd0, 2);
        run = 1'b0;
        step();
        check_eq("stop_delta", 64'(delta), 64'd0);
        check_eq("stop_gate", 64'(gate), 64'd0);
        play(2'd0, 6);
        check_eq("restart_idx", 64'(st_idx.size() > 0 ? st_idx[0] : -1), 64'd0);
        check_eq("restart_len", 64'(st_cyc.size() > 1 ? st_cyc[1] - st_cyc[0] : 0), 64'd4);
        stop_run();

        num_notes = 3'd0; note_dur = 16'd0;
        play(2'd0, 10);
        check_eq("min_starts", 64'(st_idx.size()), 64'd10);
        for (int i = 0; i < st_idx.size(); i++)
            check_eq("min_idx", 64'(st_idx[i]), 64'd0);
        stop_run();

        num_notes = 3'd3; note_dur = 16'd1;
        play(2'd3, 64);
        seen = 0;
        for (int i = 0; i < st_idx.size(); i++) begin
            check_eq("rnd_range", 64'(st_idx[i] < 3), 64'd1);
            seen = seen | (1 << st_idx[i]);
        end
        check_eq("rnd_count", 64'(st_idx.size()), 64'd64);
        check_eq("rnd_cover", 64'(seen), 64'd7);
        stop_run();

        for (int i = 0; i < 2000; i++) begin
            sample_tick = ($urandom_range(0, 1) == 0);
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 39) == 0) run = ~run;
            if (m_play == 0 && !run) begin
                pattern   = 2'($urandom_range(0, 3));
                num_notes = 3'($urandom_range(0, 7));
                note_dur  = 16'($urandom_range(0, 5));
            end else if (pattern != 2'd2 && $urandom_range(0, 29) == 0) begin
                num_notes = 3'($urandom_range(0, 7));
            end
            step();
        end
        wr_en = 1'b0;

        sample_tick = 1'b1; num_notes = 3'd3; note_dur = 16'd4; pattern = 2'd0;
        stop_run();
        play(2'd0, 6);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_delta", 64'(delta), 64'd0);
        check_eq("async_gate", 64'(gate), 64'd0);
        check_eq("async_start", 64'(note_start), 64'd0);
        check_eq("async_idx", 64'(note_idx), 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check_eq("post_rst_gate", 64'(gate), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
